// File: rtl/rect_draw_arbiter.sv
// rect_draw_arbiter
//
// Shares the single VGA pixel-write port among three rectangle requesters
// (0 = background, 1 = car erase, 2 = car draw). One requester is granted
// at a time; its rectangle is scanned row-major into pixel writes, pixels
// falling off the screen are suppressed (oPlot low) but still take a cycle,
// and completion is reported with a one-cycle oDone pulse.
//
// Ports
//   iClock   : system clock, rising edge
//   iResetn  : asynchronous active-low reset
//   iReq     : request bits, one per requester
//   iRectX/Y : packed 8-bit origins, requester i at [8i+7:8i]
//   iRectW/H : packed 8-bit width/height, same packing
//   iRectC   : packed 3-bit colours, requester i at [3i+2:3i]
//   oGrant   : one-hot pulse when a request is accepted
//   oDone    : one-hot pulse when that requester's rectangle is finished
//   oBusy    : high whenever the arbiter is not idle
//   oX/oY    : registered pixel coordinate
//   oColour  : registered pixel colour
//   oPlot    : registered pixel write enable
//
// Build option
//   RECT_ARB_ROUND_ROBIN_EN : when defined, round-robin arbitration starting
//   after the last granted requester; otherwise fixed priority 0 > 1 > 2.

module rect_draw_arbiter #(
    parameter logic [7:0] X_SCREEN_PIXELS = 8'd160,
    parameter logic [6:0] Y_SCREEN_PIXELS = 7'd120
) (
    input  logic        iClock,
    input  logic        iResetn,
    input  logic [2:0]  iReq,
    input  logic [23:0] iRectX,
    input  logic [23:0] iRectY,
    input  logic [23:0] iRectW,
    input  logic [23:0] iRectH,
    input  logic [8:0]  iRectC,
    output logic [2:0]  oGrant,
    output logic [2:0]  oDone,
    output logic        oBusy,
    output logic [7:0]  oX,
    output logic [7:0]  oY,
    output logic [2:0]  oColour,
    output logic        oPlot
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t      state, state_next;

    logic [1:0]  win;
    logic [2:0]  win_onehot;
    logic [7:0]  sel_x, sel_y, sel_w, sel_h;
    logic [2:0]  sel_c;

    logic [7:0]  x0, y0, w, h;
    logic [2:0]  col;
    logic [2:0]  owner;
    logic [7:0]  cx, cy;

    logic [7:0]  x0_n, y0_n, w_n, h_n;
    logic [2:0]  col_n, owner_n;
    logic [7:0]  cx_n, cy_n;
    logic [2:0]  grant_n, done_n;
    logic        plot_n;
    logic [7:0]  ox_n, oy_n;
    logic [2:0]  colour_n;

    logic [8:0]  sum_x, sum_y;
    logic        last_col, last_row;

`ifdef RECT_ARB_ROUND_ROBIN_EN
    logic [1:0]  ptr, ptr_n;

    // Search starts one past the last granted requester and wraps mod 3.
    always_comb begin
        win = 2'd0;
        case (ptr)
            2'd0:    win = iReq[1] ? 2'd1 : (iReq[2] ? 2'd2 : 2'd0);
            2'd1:    win = iReq[2] ? 2'd2 : (iReq[0] ? 2'd0 : 2'd1);
            default: win = iReq[0] ? 2'd0 : (iReq[1] ? 2'd1 : 2'd2);
        endcase
    end
`else
    // Fixed priority: lowest index wins.
    always_comb begin
        win = iReq[0] ? 2'd0 : (iReq[1] ? 2'd1 : 2'd2);
    end
`endif

    assign win_onehot = 3'b001 << win;

    // Pull the winner's rectangle out of the packed request buses.
    always_comb begin
        sel_x = iRectX[7:0];
        sel_y = iRectY[7:0];
        sel_w = iRectW[7:0];
        sel_h = iRectH[7:0];
        sel_c = iRectC[2:0];
        case (win)
            2'd1: begin
                sel_x = iRectX[15:8];
                sel_y = iRectY[15:8];
                sel_w = iRectW[15:8];
                sel_h = iRectH[15:8];
                sel_c = iRectC[5:3];
            end
            2'd2: begin
                sel_x = iRectX[23:16];
                sel_y = iRectY[23:16];
                sel_w = iRectW[23:16];
                sel_h = iRectH[23:16];
                sel_c = iRectC[8:6];
            end
            default: ;
        endcase
    end

    assign last_col = (cx == w - 8'd1);
    assign last_row = (cy == h - 8'd1);
    assign oBusy    = (state != IDLE);

    // Next-state and next-output logic. Pixel outputs are computed one
    // step ahead (from the next scan position) so they can be registered
    // and still appear in the same cycle as the grant.
    always_comb begin
        state_next = state;
        x0_n       = x0;
        y0_n       = y0;
        w_n        = w;
        h_n        = h;
        col_n      = col;
        owner_n    = owner;
        cx_n       = cx;
        cy_n       = cy;
        grant_n    = 3'b000;
        done_n     = 3'b000;
        plot_n     = 1'b0;
        ox_n       = oX;
        oy_n       = oY;
        colour_n   = oColour;
        sum_x      = 9'd0;
        sum_y      = 9'd0;
`ifdef RECT_ARB_ROUND_ROBIN_EN
        ptr_n      = ptr;
`endif

        case (state)
            IDLE: begin
                if (|iReq) begin
                    x0_n    = sel_x;
                    y0_n    = sel_y;
                    w_n     = sel_w;
                    h_n     = sel_h;
                    col_n   = sel_c;
                    owner_n = win_onehot;
                    cx_n    = 8'd0;
                    cy_n    = 8'd0;
                    grant_n = win_onehot;
`ifdef RECT_ARB_ROUND_ROBIN_EN
                    ptr_n   = win;
`endif
                    // Degenerate rectangles skip DRAW and never plot.
                    if (sel_w == 8'd0 || sel_h == 8'd0) begin
                        state_next = FIN;
                    end else begin
                        state_next = DRAW;
                        sum_x      = {1'b0, sel_x};
                        sum_y      = {1'b0, sel_y};
                        ox_n       = sum_x[7:0];
                        oy_n       = sum_y[7:0];
                        colour_n   = sel_c;
                        plot_n     = (sum_x < {1'b0, X_SCREEN_PIXELS}) &&
                                     (sum_y < {2'b00, Y_SCREEN_PIXELS});
                    end
                end
            end

            DRAW: begin
                if (last_col && last_row) begin
                    state_next = FIN;
                    done_n     = owner;
                end else begin
                    if (last_col) begin
                        cx_n = 8'd0;
                        cy_n = cy + 8'd1;
                    end else begin
                        cx_n = cx + 8'd1;
                    end
                    sum_x    = {1'b0, x0} + {1'b0, cx_n};
                    sum_y    = {1'b0, y0} + {1'b0, cy_n};
                    ox_n     = sum_x[7:0];
                    oy_n     = sum_y[7:0];
                    colour_n = col;
                    plot_n   = (sum_x < {1'b0, X_SCREEN_PIXELS}) &&
                               (sum_y < {2'b00, Y_SCREEN_PIXELS});
                end
            end

            FIN: begin
                state_next = IDLE;
                // Coming from DRAW, oDone is already high during FIN. Coming
                // straight from IDLE (empty rectangle), it is issued on the
                // way out so it trails the grant by one cycle.
                if (oDone == 3'b000) begin
                    done_n = owner;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any rectangle silently.
    always_ff @(posedge iClock or negedge iResetn) begin
        if (!iResetn) begin
            state   <= IDLE;
            x0      <= 8'd0;
            y0      <= 8'd0;
            w       <= 8'd0;
            h       <= 8'd0;
            col     <= 3'd0;
            owner   <= 3'd0;
            cx      <= 8'd0;
            cy      <= 8'd0;
            oGrant  <= 3'd0;
            oDone   <= 3'd0;
            oPlot   <= 1'b0;
            oX      <= 8'd0;
            oY      <= 8'd0;
            oColour <= 3'd0;
`ifdef RECT_ARB_ROUND_ROBIN_EN
            ptr     <= 2'd2;
`endif
        end else begin
            state   <= state_next;
            x0      <= x0_n;
            y0      <= y0_n;
            w       <= w_n;
            h       <= h_n;
            col     <= col_n;
            owner   <= owner_n;
            cx      <= cx_n;
            cy      <= cy_n;
            oGrant  <= grant_n;
            oDone   <= done_n;
            oPlot   <= plot_n;
            oX      <= ox_n;
            oY      <= oy_n;
            oColour <= colour_n;
`ifdef RECT_ARB_ROUND_ROBIN_EN
            ptr     <= ptr_n;
`endif
        end
    end

endmodule

// File: tb/tb_rect_draw_arbiter.sv
// tb_rect_draw_arbiter
//
// Scoreboard bench for rect_draw_arbiter. Stimulus pushes expected grant,
// pixel and done events (with the expected cycle gap from the previous
// event) into a queue; a monitor sampling on the falling edge pops and
// compares each event the DUT presents. Arbitration order is predicted by
// a small model that follows RECT_ARB_ROUND_ROBIN_EN.

module tb_rect_draw_arbiter;

    logic        iClock;
    logic        iResetn;
    logic [2:0]  iReq;
    logic [23:0] iRectX, iRectY, iRectW, iRectH;
    logic [8:0]  iRectC;
    logic [2:0]  oGrant, oDone;
    logic        oBusy;
    logic [7:0]  oX, oY;
    logic [2:0]  oColour;
    logic        oPlot;

    typedef struct {
        int          kind;
        logic [18:0] data;
        int          gap;
    } exp_t;

    localparam int KGRANT = 0;
    localparam int KDONE  = 1;
    localparam int KPIX   = 2;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   lastEvt = 0;
    int   lastGrant = 2;

    rect_draw_arbiter dut (
        .iClock  (iClock),
        .iResetn (iResetn),
        .iReq    (iReq),
        .iRectX  (iRectX),
        .iRectY  (iRectY),
        .iRectW  (iRectW),
        .iRectH  (iRectH),
        .iRectC  (iRectC),
        .oGrant  (oGrant),
        .oDone   (oDone),
        .oBusy   (oBusy),
        .oX      (oX),
        .oY      (oY),
        .oColour (oColour),
        .oPlot   (oPlot)
    );

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    // Arbitration model used to predict grant order.
    function automatic int pickWinner(input logic [2:0] req, input int last);
        int r;
        r = 0;
`ifdef RECT_ARB_ROUND_ROBIN_EN
        for (int k = 3; k >= 1; k--) begin
            if (req[(last + k) % 3]) r = (last + k) % 3;
        end
`else
        for (int i = 2; i >= 0; i--) begin
            if (req[i]) r = i;
        end
`endif
        return r;
    endfunction

    function automatic string kindName(input int k);
        if (k == KGRANT) return "grant";
        if (k == KDONE) return "done";
        return "pixel";
    endfunction

    task automatic pushEv(input int kind, input logic [2:0] onehot, input int gap);
        exp_t e;
        e.kind = kind;
        e.data = {16'd0, onehot};
        e.gap  = gap;
        q.push_back(e);
    endtask

    task automatic pushPix(input logic [7:0] x, input logic [7:0] y,
                           input logic [2:0] c, input int gap);
        exp_t e;
        e.kind = KPIX;
        e.data = {x, y, c};
        e.gap  = gap;
        q.push_back(e);
    endtask

    task automatic setRect(input int idx, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] w, input logic [7:0] h, input logic [2:0] c);
        iRectX[idx*8 +: 8] = x;
        iRectY[idx*8 +: 8] = y;
        iRectW[idx*8 +: 8] = w;
        iRectH[idx*8 +: 8] = h;
        iRectC[idx*3 +: 3] = c;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor side: compare one observed event against the queue head.
    task automatic popCompare(input int kind, input logic [18:0] data);
        exp_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_%s: got data %h at cycle %0d, expected no event",
                     kindName(kind), data, cyc);
        end else begin
            e = q.pop_front();
            if (e.kind != kind || e.data !== data ||
                (e.gap >= 0 && (cyc - lastEvt) != e.gap)) begin
                fails++;
                $display("[TB] FAIL %s: got %s data %h gap %0d, expected %s data %h gap %0d",
                         kindName(e.kind), kindName(kind), data, cyc - lastEvt,
                         kindName(e.kind), e.data, e.gap);
            end
        end
        lastEvt = cyc;
    endtask

    always @(negedge iClock) begin
        cyc++;
        if (iResetn) begin
            if (oGrant != 3'b000) popCompare(KGRANT, {16'd0, oGrant});
            if (oDone != 3'b000)  popCompare(KDONE, {16'd0, oDone});
            if (oPlot)            popCompare(KPIX, {oX, oY, oColour});
        end
    end

    task automatic waitGrant(input string name);
        int n;
        n = 0;
        do begin
            @(negedge iClock);
            n++;
        end while (oGrant == 3'b000 && n < 100);
        if (oGrant == 3'b000) begin
            tests++;
            fails++;
            $display("[TB] FAIL %s_timeout: got no grant, expected one within 100 cycles", name);
        end
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((q.size() != 0 || oBusy) && n < 300) begin
            @(negedge iClock);
            n++;
        end
        repeat (3) @(negedge iClock);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain: got %0d events outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_grant"},  {5'd0, oGrant}, 8'd0);
        checkOutput({name, "_done"},   {5'd0, oDone}, 8'd0);
        checkOutput({name, "_busy"},   {7'd0, oBusy}, 8'd0);
        checkOutput({name, "_plot"},   {7'd0, oPlot}, 8'd0);
        checkOutput({name, "_x"},      oX, 8'd0);
        checkOutput({name, "_y"},      oY, 8'd0);
        checkOutput({name, "_colour"}, {5'd0, oColour}, 8'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] req);
        @(posedge iClock);
        #1;
        iReq = req;
    endtask

    initial begin
        logic [2:0] req;
        int         wn;

        iResetn = 1'b0;
        iReq    = 3'b000;
        iRectX  = '0;
        iRectY  = '0;
        iRectW  = '0;
        iRectH  = '0;
        iRectC  = '0;

        repeat (2) @(negedge iClock);
        checkAllZero("reset");
        @(posedge iClock);
        #1;
        iResetn = 1'b1;

        // Plain 2x2 draw from the background requester.
        setRect(0, 8'd10, 8'd20, 8'd2, 8'd2, 3'b010);
        pushEv(KGRANT, 3'b001, -1);
        pushPix(8'd10, 8'd20, 3'd2, 0);
        pushPix(8'd11, 8'd20, 3'd2, 1);
        pushPix(8'd10, 8'd21, 3'd2, 1);
        pushPix(8'd11, 8'd21, 3'd2, 1);
        pushEv(KDONE, 3'b001, 1);
        lastGrant = 0;
        applyStimulus(3'b001);
        waitGrant("t1");
        checkOutput("t1_busy_at_grant", {7'd0, oBusy}, 8'd1);
        iReq = 3'b000;
        waitDrain("t1");

        // All three request 1x1 at once; each drops its request when granted.
        setRect(0, 8'd1, 8'd1, 8'd1, 8'd1, 3'd1);
        setRect(1, 8'd2, 8'd2, 8'd1, 8'd1, 3'd2);
        setRect(2, 8'd3, 8'd3, 8'd1, 8'd1, 3'd3);
        req = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wn = pickWinner(req, lastGrant);
            pushEv(KGRANT, 3'b001 << wn, (i == 0) ? -1 : 2);
            pushPix(8'(wn + 1), 8'(wn + 1), 3'(wn + 1), 0);
            pushEv(KDONE, 3'b001 << wn, 1);
            req[wn] = 1'b0;
            lastGrant = wn;
        end
        applyStimulus(3'b111);
        for (int i = 0; i < 3; i++) begin
            waitGrant("t2");
            iReq = iReq & ~oGrant;
        end
        waitDrain("t2");

        // Zero-width rectangle: grant then done, no pixels.
        setRect(1, 8'd40, 8'd40, 8'd0, 8'd5, 3'd7);
        pushEv(KGRANT, 3'b010, -1);
        pushEv(KDONE, 3'b010, 1);
        lastGrant = 1;
        applyStimulus(3'b010);
        waitGrant("t3");
        iReq = 3'b000;
        waitDrain("t3");

        // Clipping at the bottom-right corner of the screen.
        setRect(2, 8'd158, 8'd119, 8'd4, 8'd2, 3'd5);
        pushEv(KGRANT, 3'b100, -1);
        pushPix(8'd158, 8'd119, 3'd5, 0);
        pushPix(8'd159, 8'd119, 3'd5, 1);
        pushEv(KDONE, 3'b100, 7);
        lastGrant = 2;
        applyStimulus(3'b100);
        waitGrant("t4");
        iReq = 3'b000;
        waitDrain("t4");

        // Reset during the third cycle of a 4x4 draw.
        setRect(0, 8'd0, 8'd0, 8'd4, 8'd4, 3'd6);
        pushEv(KGRANT, 3'b001, -1);
        pushPix(8'd0, 8'd0, 3'd6, 0);
        pushPix(8'd1, 8'd0, 3'd6, 1);
        applyStimulus(3'b001);
        waitGrant("t5");
        @(posedge iClock);
        @(posedge iClock);
        #2;
        iResetn = 1'b0;
        setRect(0, 8'd5, 8'd6, 8'd1, 8'd1, 3'd4);
        @(negedge iClock);
        checkAllZero("midreset");
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("[TB] FAIL midreset_events: got %0d outstanding, expected 0", q.size());
            q.delete();
        end
        lastGrant = 2;
        pushEv(KGRANT, 3'b001, -1);
        pushPix(8'd5, 8'd6, 3'd4, 0);
        pushEv(KDONE, 3'b001, 1);
        lastGrant = 0;
        @(posedge iClock);
        #1;
        iResetn = 1'b1;
        waitGrant("t5b");
        iReq = 3'b000;
        waitDrain("t5");

        // Requesters 0 and 1 held continuously with 1x1 rectangles.
        setRect(0, 8'd7, 8'd8, 8'd1, 8'd1, 3'd1);
        setRect(1, 8'd9, 8'd10, 8'd1, 8'd1, 3'd6);
        for (int i = 0; i < 4; i++) begin
            wn = pickWinner(3'b011, lastGrant);
            pushEv(KGRANT, 3'b001 << wn, (i == 0) ? -1 : 2);
            if (wn == 0) pushPix(8'd7, 8'd8, 3'd1, 0);
            else         pushPix(8'd9, 8'd10, 3'd6, 0);
            pushEv(KDONE, 3'b001 << wn, 1);
            lastGrant = wn;
        end
        applyStimulus(3'b011);
        for (int i = 0; i < 4; i++) begin
            waitGrant("t6");
        end
        iReq = 3'b000;
        waitDrain("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
